sub64_seq: RTL
==============

Name: sub64_seq

Overview:
- Multi-cycle W-bit subtractor: diff = a - b - b_in, using one CHUNK-bit borrow-ripple slice.
- Processes one CHUNK slice per clock, least significant slice first. Borrow is carried between slices in a register.
- Sits beside the combinational adders as the low-area inverse-operation unit.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 64, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 32, bits processed per RUN cycle; N = WIDTH/CHUNK slices, N >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, b_in are valid
- in_ready  output  1  block can accept an operation; high only in IDLE
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow in; subtracted at the LSB
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - b_in, modulo 2^WIDTH
- b_out  output  1  final borrow; 1 iff a < b + b_in, unsigned
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset, asynchronous, any state:
  - state = IDLE, slice index = 0, borrow register = 0.
  - out_valid = 0, diff = 0, b_out = 0, overflow = 0.
  - in_ready = 1 as soon as rst_n is released.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. On in_valid && in_ready at a clock edge:
    - capture a and b into operand registers;
    - borrow register = b_in, index = 0;
    - clear diff, b_out and overflow;
    - go to RUN.
    - With in_valid = 0, stay in IDLE.
  - RUN, each cycle:
    - s = a_reg[idx*CHUNK +: CHUNK] - b_reg[idx*CHUNK +: CHUNK] - borrow, computed CHUNK+1 bits wide;
    - diff[idx slice] = s[CHUNK-1:0];
    - borrow register = s[CHUNK];
    - index increments.
    - On the edge that processes slice N-1: b_out = final borrow, overflow computed from the captured MSBs and the new diff MSB, out_valid = 1, go to DONE.
  - DONE: in_ready = 0. diff, b_out and overflow are held stable while out_valid = 1 and out_ready = 0. On out_valid && out_ready: out_valid = 0, go to IDLE. diff, b_out and overflow keep their values until the next accept.
- Latency: the accept edge is edge k; out_valid is first high after edge k+N (k+2 at the defaults).
- Throughput: one operation per N+2 cycles when out_ready is held high.
- Input changes while not in IDLE are ignored; operands are used only from the capture registers.
- in_ready is a function of state only and never depends on in_valid.
- b_in = 1 borrows exactly 1 at bit 0. Borrow crosses every slice boundary correctly, including a full-width borrow chain.
- N = 1: RUN lasts one cycle.
- The output handshake and the input handshake never complete in the same cycle, because in_ready = 0 in DONE.

Test Plan:
- Reset release, no traffic -> in_ready = 1, out_valid = 0, diff = 0, b_out = 0, overflow = 0.
- a = 0x0000_0001_0000_0000, b = 1, b_in = 0 -> after 2 cycles: diff = 0x0000_0000_FFFF_FFFF, b_out = 0, overflow = 0. This exercises the borrow across the slice boundary.
- a = 0, b = 0, b_in = 1 -> diff = 0xFFFF_FFFF_FFFF_FFFF, b_out = 1, overflow = 0.
- a = 0x8000_0000_0000_0000, b = 1 -> diff = 0x7FFF_FFFF_FFFF_FFFF, b_out = 0, overflow = 1.
- Hold out_ready = 0 for 5 cycles with in_valid = 1 and new operands driven -> in_ready = 0, result stable. Then raise out_ready for 1 cycle -> IDLE, and the next operands are accepted on the following edge.
- Assert rst_n = 0 during RUN after slice 0 -> immediately out_valid = 0, diff = 0, state IDLE. Then a = 5, b = 3 -> diff = 2, b_out = 0.

Source files
------------

// File: rtl/sub64_seq.sv
// sub64_seq: multi-cycle WIDTH-bit subtractor (diff = a - b - b_in).
// A single CHUNK-bit borrow-ripple slice is reused once per clock, LSB slice
// first, with the inter-slice borrow held in a register. Valid/ready on both
// sides; only one operation is in flight at a time.
module sub64_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [IDX_W-1:0]   r_idx;
    logic               r_borrow;
    logic               r_b_out;
    logic               r_overflow;
    logic               r_out_valid;

    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK:0]     w_s;
    logic               w_accept;
    logic               w_last;
    logic               w_release;

    // One slice of the subtraction; the extra top bit of w_s is the borrow out.
    always_comb begin
        w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
        w_b_slice = r_b[r_idx*CHUNK +: CHUNK];
        w_s       = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{CHUNK{1'b0}}, r_borrow};
    end

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_state == RUN) && (r_idx == LAST_IDX);
    assign w_release = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign b_out     = r_b_out;
    assign overflow  = r_overflow;

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last slice,
    // DONE -> IDLE once the consumer takes the result.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (w_release) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one slice written per RUN cycle,
    // flags and out_valid set on the final slice, out_valid cleared on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_idx       <= '0;
            r_borrow    <= 1'b0;
            r_b_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a        <= a;
                r_b        <= b;
                r_borrow   <= b_in;
                r_idx      <= '0;
                r_diff     <= '0;
                r_b_out    <= 1'b0;
                r_overflow <= 1'b0;
            end else if (r_state == RUN) begin
                r_diff[r_idx*CHUNK +: CHUNK] <= w_s[CHUNK-1:0];
                r_borrow                     <= w_s[CHUNK];
                if (w_last) begin
                    r_idx       <= '0;
                    r_b_out     <= w_s[CHUNK];
                    r_overflow  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_s[CHUNK-1] != r_a[WIDTH-1]);
                    r_out_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
